cr_prefix_attach_ob_buf: RTL
============================

// Module: cr_prefix_attach_ob_buf
// PURPOSE
//  Outbound elastic buffer sitting directly downstream of the prefix attach stage: accepts the prefixed AXI4-S
//  data-path stream (prefix_attach_ob_out) and re-presents it to the next engine stage. Decouples stage
//  backpressure, registers all outputs (no comb path ob_tready->ib_tready), tracks occupancy, counts frames.
// PARAMETERS
//  DEPTH   16  beat entries; power of 2, 4..64
//  DW      64  tdata width; tstrb width = DW/8
//  UW      8   tuser width
// PORTS
//  clk            in   1       single clock; all logic rising-edge
//  rst            in   1       asynchronous, active-high reset
//  ib_tvalid      in   1       upstream beat valid
//  ib_tlast       in   1       last beat of frame
//  ib_tuser       in   UW      sideband, carried unmodified
//  ib_tstrb       in   DW/8    byte strobes, carried unmodified
//  ib_tdata       in   DW      data
//  ib_tready      out  1       buffer can accept a beat this cycle
//  ob_tvalid      out  1       downstream beat valid
//  ob_tlast/ob_tuser/ob_tstrb/ob_tdata  out  1/UW/DW/8/DW  downstream beat
//  ob_tready      in   1       downstream accepts
//  clr_stats      in   1       1-cycle pulse: clear frame_cnt and occ_hwm
//  occupancy      out  $clog2(DEPTH)+1  beats held (incl. output register)
//  occ_hwm        out  $clog2(DEPTH)+1  high-water mark of occupancy
//  frame_cnt      out  32      frames sent downstream (tlast handshakes), saturating at 32'hFFFF_FFFF
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers/counters 0; ib_tready=0 during rst, 1 first cycle after;
//    ob_tvalid=0, ob_tlast=0, ob_tuser/ob_tstrb/ob_tdata=0; occupancy=occ_hwm=frame_cnt=0. Assert mid-frame
//    drops all buffered beats; no partial frame is resumed.
//  - Push: ib_tvalid&ib_tready. Pop: ob_tvalid&ob_tready. Storage = flop array + output register.
//  - ib_tready = (occupancy < DEPTH), registered from next-state count; full => ib_tready=0 even if a pop
//    occurs the same cycle (no fall-through from ob_tready).
//  - Latency: beat pushed in cycle N drives ob_tvalid in N+1 when buffer empty; back-to-back push/pop
//    sustains 1 beat/clk.
//  - ob_* held stable while ob_tvalid&!ob_tready (AXI rule); ob_tvalid never drops without pop.
//  - Simultaneous push+pop: occupancy unchanged; ordering preserved; at occupancy=1 the pushed beat goes
//    to output register next cycle.
//  - Pointers wrap modulo DEPTH; occupancy range 0..DEPTH.
//  - occ_hwm <= max(occ_hwm, occupancy) each cycle; clr_stats sets occ_hwm=occupancy, frame_cnt=0;
//    clr_stats coincident with a tlast pop: frame_cnt=1.
//  - No field inspected or modified; tuser/tstrb pass bit-exact.
// CONFIGURATION
//  CR_PREFIX_ATTACH_OB_SAF_EN defined: store-and-forward. ob_tvalid asserted only when >=1 complete
//   frame (tlast beat) is buffered, or when buffer is full with no tlast (oversize frame: cut-through
//   fallback until that frame's tlast pops, preventing deadlock). Frame count of buffered tlasts kept
//   internally; push+pop of tlast same cycle leaves it unchanged.
//  Undefined: cut-through; ob_tvalid whenever occupancy>0. Default: undefined.
// TESTING
//  1 Reset: rst=1 mid-stream with 5 beats held -> all outputs 0; after release ib_tready=1, occupancy=0.
//  2 Stream 3-beat frame, ob_tready=1 -> ob beats D0..D2 at N+1..N+3, tlast on D2, frame_cnt=1.
//  3 ob_tready=0, push 16 beats (DEPTH=16) -> ib_tready=0 after 16th, occupancy=16, occ_hwm=16;
//    raise ob_tready -> ib_tready=1 cycle after first pop, no beat lost/duplicated.
//  4 Random valid/ready 10k beats, mixed tstrb/tuser -> ob sequence bit-exact to ib; stall stability held.
//  5 SAF_EN: 4-beat frame with 3-cycle gap before tlast -> ob_tvalid=0 until tlast pushed; 20-beat frame
//    (DEPTH=16) -> fallback drains, all 20 beats out, no hang.
//  6 frame_cnt preset to 32'hFFFF_FFFE via 2 frames of force -> stays 32'hFFFF_FFFF; clr_stats -> 0.

Source files
------------

// File: rtl/cr_prefix_attach_ob_buf.sv
// Outbound elastic buffer behind the prefix attach stage: flop FIFO plus output register, occupancy and frame stats.
// Define CR_PREFIX_ATTACH_OB_SAF_EN for store-and-forward release with an oversize-frame cut-through fallback.
module cr_prefix_attach_ob_buf #(
   parameter int DEPTH = 16,
   parameter int DW    = 64,
   parameter int UW    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ib_tvalid,
   input  logic                      ib_tlast,
   input  logic [UW-1:0]             ib_tuser,
   input  logic [DW/8-1:0]           ib_tstrb,
   input  logic [DW-1:0]             ib_tdata,
   output logic                      ib_tready,
   output logic                      ob_tvalid,
   output logic                      ob_tlast,
   output logic [UW-1:0]             ob_tuser,
   output logic [DW/8-1:0]           ob_tstrb,
   output logic [DW-1:0]             ob_tdata,
   input  logic                      ob_tready,
   input  logic                      clr_stats,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic [$clog2(DEPTH):0]    occ_hwm,
   output logic [31:0]               frame_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = DW + DW/8 + UW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [BW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] mem_cnt, occ_nxt;
   logic [BW-1:0] in_beat, head;
   logic          push, pop, out_free, perm, byp_ok, ld_mem, ld_byp, wr_mem, tl_pop;

   assign in_beat  = {ib_tlast, ib_tuser, ib_tstrb, ib_tdata};
   assign head     = mem[rd_ptr];
   assign push     = ib_tvalid & ib_tready;
   assign pop      = ob_tvalid & ob_tready;
   assign out_free = ~ob_tvalid | ob_tready;
   assign tl_pop   = pop & ob_tlast;

`ifdef CR_PREFIX_ATTACH_OB_SAF_EN
   logic [CW-1:0] tl_cnt;
   logic          fb, full_stuck;

   // A full FIFO holding no tlast can never complete its frame: stream it out (fallback) until its tlast leaves.
   assign full_stuck = (mem_cnt == FULL) && (tl_cnt == '0);
   assign perm       = (tl_cnt != '0) | fb | full_stuck | (push & ib_tlast);
   assign byp_ok     = ib_tlast | fb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tl_cnt <= '0;
         fb     <= 1'b0;
      end else begin
         tl_cnt <= tl_cnt + CW'(wr_mem & ib_tlast) - CW'(ld_mem & head[BW-1]);
         fb     <= (fb | full_stuck) & ~((ld_mem & head[BW-1]) | (ld_byp & ib_tlast));
      end
   end
`else
   assign perm   = 1'b1;
   assign byp_ok = 1'b1;
`endif

   // Output register refills from the FIFO head, or straight from the input when the FIFO is empty.
   assign ld_mem  = out_free & (mem_cnt != '0) & perm;
   assign ld_byp  = out_free & (mem_cnt == '0) & push & byp_ok;
   assign wr_mem  = push & ~ld_byp;
   assign occ_nxt = occupancy + CW'(push) - CW'(pop);

   always_ff @(posedge clk) begin
      if (wr_mem) mem[wr_ptr] <= in_beat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_cnt   <= '0;
         occupancy <= '0;
         ib_tready <= 1'b0;
         ob_tvalid <= 1'b0;
         ob_tlast  <= 1'b0;
         ob_tuser  <= '0;
         ob_tstrb  <= '0;
         ob_tdata  <= '0;
         occ_hwm   <= '0;
         frame_cnt <= '0;
      end else begin
         wr_ptr    <= wr_ptr + AW'(wr_mem);
         rd_ptr    <= rd_ptr + AW'(ld_mem);
         mem_cnt   <= mem_cnt + CW'(wr_mem) - CW'(ld_mem);
         occupancy <= occ_nxt;
         ib_tready <= (occ_nxt < FULL);
         if (out_free) ob_tvalid <= ld_mem | ld_byp;
         if (ld_mem)
            {ob_tlast, ob_tuser, ob_tstrb, ob_tdata} <= head;
         else if (ld_byp)
            {ob_tlast, ob_tuser, ob_tstrb, ob_tdata} <= in_beat;
         if (clr_stats)
            occ_hwm <= occupancy;
         else if (occupancy > occ_hwm)
            occ_hwm <= occupancy;
         if (clr_stats)
            frame_cnt <= {31'b0, tl_pop};
         else if (tl_pop && (frame_cnt != 32'hFFFF_FFFF))
            frame_cnt <= frame_cnt + 32'd1;
      end
   end
endmodule
